// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Latches one-cycle edge pulses from the edge-detector bank into per-channel
// pending flags. It hands them out one at a time on a valid/ready event port,
// choosing among pending channels with a round-robin arbiter.
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   pos_edge     [N]     one-cycle edge pulses, one bit per channel
//   mask         [N]     channel enable (0 = ignored, pending dropped)
//   evt_valid    out     event available on evt_idx
//   evt_idx      [IDXW]  channel number of the current event
//   evt_ready    in      consumer accepts the event when high with evt_valid
//   pending      [N]     registered pending flags
//   overrun      [N]     sticky overrun flags (edge on an already-pending ch)
//   overrun_clr  in      clears all overrun flags (a new overrun wins)
//   evt_count    [CNTW]  completed handshakes, wraps
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
   parameter int N    = 20,
   parameter int IDXW = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N-1:0]    pos_edge,
   input  logic [N-1:0]    mask,
   output logic            evt_valid,
   output logic [IDXW-1:0] evt_idx,
   input  logic            evt_ready,
   output logic [N-1:0]    pending,
   output logic [N-1:0]    overrun,
   input  logic            overrun_clr,
   output logic [CNTW-1:0] evt_count
);

   logic [N-1:0]    req;
   logic [N-1:0]    edge_in;
   logic [N-1:0]    gnt_vec;
   logic [N-1:0]    ovr_set;
   logic            slot_free;
   logic            found;
   logic            grant;
   logic [IDXW-1:0] gnt_idx;
   logic [IDXW-1:0] rr_ptr;

   // Round-robin search: walk channels rr_ptr, rr_ptr+1, ... modulo N and
   // take the first one with an enabled pending flag.
   always_comb begin
      logic [IDXW:0] cand;
      req       = pending & mask;
      edge_in   = pos_edge & mask;
      slot_free = !evt_valid || evt_ready;
      found     = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_ptr} + (IDXW+1)'(k);
         if (cand >= (IDXW+1)'(N))
            cand = cand - (IDXW+1)'(N);
         if (!found && req[cand[IDXW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[IDXW-1:0];
         end
      end
      grant   = slot_free && found;
      gnt_vec = grant ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
      // A fresh edge on the channel being granted becomes its next event,
      // so only a not-granted pending channel can overrun.
      ovr_set = edge_in & pending & ~gnt_vec;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending   <= '0;
         overrun   <= '0;
         evt_valid <= 1'b0;
         evt_idx   <= '0;
         evt_count <= '0;
         rr_ptr    <= '0;
      end else begin
         pending <= (pending & mask & ~gnt_vec) | edge_in;
         overrun <= (overrun & {N{~overrun_clr}}) | ovr_set;
         if (evt_valid && evt_ready)
            evt_count <= evt_count + CNTW'(1);
         if (slot_free) begin
            evt_valid <= grant;
            if (grant) begin
               evt_idx <= gnt_idx;
               rr_ptr  <= (gnt_idx == IDXW'(N-1)) ? '0 : gnt_idx + IDXW'(1);
            end
         end
      end
   end

endmodule
